// File: rtl/stats_pkg.sv
// Shared statistics-datapath types and constants for the divider sharing logic.
package stats_pkg;

  localparam int unsigned DIV_NUM_W = 32;
  localparam int unsigned DIV_DEN_W = 16;

  // Tag id is sized for the largest supported requester count (16) so the
  // record type does not depend on a per-instance parameter.
  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned TAG_ID_W = $clog2(MAX_REQ);

  localparam logic [DIV_NUM_W-1:0] QUOT_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [DIV_NUM_W-1:0] QUOT_NEG_SAT = 32'h8000_0000;

  // One in-flight division: owner id, divide-by-zero flag and dividend sign.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                dz;
    logic                num_sign;
  } div_tag_t;

  // Saturated quotient returned for a zero divisor.
  function automatic logic [DIV_NUM_W-1:0] dz_quot(input logic num_sign);
    return num_sign ? QUOT_NEG_SAT : QUOT_POS_SAT;
  endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// Requester-side and divider-side signals of the shared divider arbiter.
interface div_share_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import stats_pkg::*;

  logic [N_REQ-1:0]           req_in;
  logic [N_REQ*DIV_NUM_W-1:0] num_in;
  logic [N_REQ*DIV_DEN_W-1:0] den_in;
  logic [N_REQ-1:0]           ack_out;
  logic [DIV_NUM_W-1:0]       quot_out;
  logic                       err_out;
  logic [N_REQ-1:0]           busy_out;
  logic                       div_rfd_in;
  logic [DIV_NUM_W-1:0]       div_num_out;
  logic [DIV_DEN_W-1:0]       div_den_out;
  logic [DIV_NUM_W-1:0]       div_quot_in;

  // Environment side: requesters plus the divider core.
  modport master (
    output req_in, num_in, den_in, div_rfd_in, div_quot_in,
    input  ack_out, quot_out, err_out, busy_out, div_num_out, div_den_out
  );

  // Arbiter side.
  modport slave (
    input  req_in, num_in, den_in, div_rfd_in, div_quot_in,
    output ack_out, quot_out, err_out, busy_out, div_num_out, div_den_out
  );

endinterface

// File: rtl/div_share_arbiter_tag.sv
// Fixed-depth shift register of in-flight tags, cleared asynchronously.
module div_tag_pipe
  import stats_pkg::*;
#(
  parameter int unsigned DEPTH = 37
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  div_tag_t tag_in,
  output div_tag_t tag_out
);

  div_tag_t stage_q [DEPTH];
  div_tag_t stage_d [DEPTH];

  // Shift one stage per cycle; bubbles enter as invalid tags.
  always_comb begin
    stage_d[0] = tag_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset discards every in-flight tag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one pipelined signed divider among N_REQ requesters.
module div_share_arbiter
  import stats_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DIV_LATENCY = 36
) (
  input  logic          clk_in,
  input  logic          rst_in,
  div_share_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]     busy_q, busy_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [DIV_NUM_W-1:0] quot_q, quot_d;
  logic                 err_q, err_d;
  logic [DIV_NUM_W-1:0] div_num_q, div_num_d;
  logic [DIV_DEN_W-1:0] div_den_q, div_den_d;

  logic [N_REQ-1:0]     elig_c;
  logic                 found_c;
  logic                 grant_vld_c;
  logic [PTR_W-1:0]     grant_id_c;
  int unsigned          cand_c;
  logic [DIV_NUM_W-1:0] num_sel_c;
  logic [DIV_DEN_W-1:0] den_sel_c;
  logic [N_REQ-1:0]     grant_oh_c;
  logic [N_REQ-1:0]     retire_oh_c;
  div_tag_t             tag_in_c;
  div_tag_t             tag_tail;

  // A requester may be granted only when idle and not being acknowledged.
  assign elig_c = bus.req_in & ~busy_q & ~ack_q;

  // First eligible requester searching upward from rr_ptr+1, wrapping.
  always_comb begin
    found_c    = 1'b0;
    grant_id_c = rr_ptr_q;
    cand_c     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = 32'(rr_ptr_q) + k;
      if (cand_c >= N_REQ) begin
        cand_c = cand_c - N_REQ;
      end
      if (!found_c && elig_c[PTR_W'(cand_c)]) begin
        found_c    = 1'b1;
        grant_id_c = PTR_W'(cand_c);
      end
    end
    grant_vld_c = found_c & bus.div_rfd_in;
  end

  // Operand mux for the granted requester.
  always_comb begin
    num_sel_c = '0;
    den_sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id_c == PTR_W'(i)) begin
        num_sel_c = bus.num_in[i*DIV_NUM_W +: DIV_NUM_W];
        den_sel_c = bus.den_in[i*DIV_DEN_W +: DIV_DEN_W];
      end
    end
  end

  // Tag for the issued operation; an invalid tag marks a bubble.
  always_comb begin
    tag_in_c = '0;
    if (grant_vld_c) begin
      tag_in_c.valid    = 1'b1;
      tag_in_c.id       = TAG_ID_W'(grant_id_c);
      tag_in_c.dz       = (den_sel_c == '0);
      tag_in_c.num_sign = num_sel_c[DIV_NUM_W-1];
    end
  end

  // Tail is valid exactly in the cycle the divider presents its quotient.
  div_tag_pipe #(
    .DEPTH (DIV_LATENCY + 1)
  ) u_tag_pipe (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tag_in  (tag_in_c),
    .tag_out (tag_tail)
  );

  assign grant_oh_c  = grant_vld_c    ? (N_REQ'(1) << grant_id_c)  : '0;
  assign retire_oh_c = tag_tail.valid ? (N_REQ'(1) << tag_tail.id) : '0;

  // Next-state for pointer, busy bits, operand registers and retire outputs.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    div_num_d = div_num_q;
    div_den_d = div_den_q;
    quot_d    = quot_q;
    err_d     = err_q;
    ack_d     = '0;
    // A granted requester is never the retiring one, so set/clear cannot collide.
    busy_d    = (busy_q | grant_oh_c) & ~retire_oh_c;

    if (grant_vld_c) begin
      rr_ptr_d  = grant_id_c;
      div_num_d = num_sel_c;
      div_den_d = den_sel_c;
    end

    if (tag_tail.valid) begin
      ack_d  = retire_oh_c;
      quot_d = tag_tail.dz ? dz_quot(tag_tail.num_sign) : bus.div_quot_in;
      err_d  = tag_tail.dz;
    end
  end

  // State registers; rr_ptr resets to the last requester so requester 0 wins first.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q  <= PTR_W'(N_REQ - 1);
      busy_q    <= '0;
      ack_q     <= '0;
      quot_q    <= '0;
      err_q     <= 1'b0;
      div_num_q <= '0;
      div_den_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      quot_q    <= quot_d;
      err_q     <= err_d;
      div_num_q <= div_num_d;
      div_den_q <= div_den_d;
    end
  end

  assign bus.ack_out     = ack_q;
  assign bus.busy_out    = busy_q;
  assign bus.quot_out    = quot_q;
  assign bus.err_out     = err_q;
  assign bus.div_num_out = div_num_q;
  assign bus.div_den_out = div_den_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural pipelined divider.
module tb_div_share_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned L = 36;

  logic clk_in;
  logic rst_in;

  div_share_arbiter_if #(.N_REQ(N)) bus ();

  div_share_arbiter #(
    .N_REQ       (N),
    .DIV_LATENCY (L)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Divider model: samples the driven operands and returns the quotient L cycles later.
  logic signed [31:0] q_c;
  logic [31:0]        dpipe [L];
  assign q_c = (bus.div_den_out == 16'd0) ? 32'sd0
             : ($signed(bus.div_num_out) / $signed(bus.div_den_out));
  always @(posedge clk_in) begin
    dpipe[0] <= q_c;
    for (int i = 1; i < int'(L); i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.div_quot_in = dpipe[L-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(negedge clk_in);
  endtask

  // Advance until ack_out[idx] is seen or the budget runs out.
  task automatic wait_ack(input int idx, input int max_cyc, output int cyc);
    cyc = 0;
    while (bus.ack_out[idx] !== 1'b1 && cyc < max_cyc) begin
      step();
      cyc++;
    end
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    n_cmp++; if (bus.ack_out !== 4'h0) begin n_bad++; $display("FAIL reset_ack got %h want 0", bus.ack_out); end
    n_cmp++; if (bus.busy_out !== 4'h0) begin n_bad++; $display("FAIL reset_busy got %h want 0", bus.busy_out); end
    n_cmp++; if (bus.quot_out !== 32'h0) begin n_bad++; $display("FAIL reset_quot got %h want 0", bus.quot_out); end
    n_cmp++; if (bus.err_out !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.err_out); end
    n_cmp++; if (bus.div_num_out !== 32'h0) begin n_bad++; $display("FAIL reset_div_num got %h want 0", bus.div_num_out); end
    n_cmp++; if (bus.div_den_out !== 16'h0) begin n_bad++; $display("FAIL reset_div_den got %h want 0", bus.div_den_out); end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_single();
    int cyc;
    bus.num_in[0 +: 32] = 32'd1000;
    bus.den_in[0 +: 16] = 16'd7;
    bus.req_in[0] = 1'b1;
    step();
    n_cmp++; if (bus.busy_out !== 4'b0001) begin n_bad++; $display("FAIL single_busy got %b want 0001", bus.busy_out); end
    n_cmp++; if (bus.div_num_out !== 32'd1000) begin n_bad++; $display("FAIL single_div_num got %0d want 1000", bus.div_num_out); end
    wait_ack(0, 100, cyc);
    cyc = cyc + 1;
    bus.req_in[0] = 1'b0;
    n_cmp++; if (cyc !== 38) begin n_bad++; $display("FAIL single_latency got %0d want 38", cyc); end
    n_cmp++; if (bus.quot_out !== 32'd142) begin n_bad++; $display("FAIL single_quot got %0d want 142", bus.quot_out); end
    n_cmp++; if (bus.err_out !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", bus.err_out); end
    n_cmp++; if (bus.busy_out !== 4'b0000) begin n_bad++; $display("FAIL single_busy_clr got %b want 0000", bus.busy_out); end
    step();
    n_cmp++; if (bus.ack_out !== 4'b0000) begin n_bad++; $display("FAIL single_ack_width got %b want 0000", bus.ack_out); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    pulse_reset();
    for (int i = 0; i < int'(N); i++) begin
      bus.num_in[32*i +: 32] = 32'(100 * (i + 1));
      bus.den_in[16*i +: 16] = 16'd10;
    end
    bus.req_in = 4'b1111;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (bus.busy_out !== 4'b1111) begin n_bad++; $display("FAIL b2b_busy got %b want 1111", bus.busy_out); end
    wait_ack(0, 100, cyc);
    cyc = cyc + 4;
    n_cmp++; if (cyc !== 38) begin n_bad++; $display("FAIL b2b_latency got %0d want 38", cyc); end
    for (int k = 0; k < int'(N); k++) begin
      n_cmp++; if (bus.ack_out !== 4'(1 << k)) begin n_bad++; $display("FAIL b2b_ack%0d got %b want %b", k, bus.ack_out, 4'(1 << k)); end
      n_cmp++; if (bus.quot_out !== 32'(10 * (k + 1))) begin n_bad++; $display("FAIL b2b_quot%0d got %0d want %0d", k, bus.quot_out, 10 * (k + 1)); end
      bus.req_in[k] = 1'b0;
      step();
    end
    n_cmp++; if (bus.ack_out !== 4'b0000) begin n_bad++; $display("FAIL b2b_ack_end got %b want 0000", bus.ack_out); end
  endtask

  task automatic test_div_zero();
    int cyc;
    bus.num_in[0 +: 32] = 32'(-5);
    bus.den_in[0 +: 16] = 16'd0;
    bus.req_in[0] = 1'b1;
    wait_ack(0, 100, cyc);
    bus.req_in[0] = 1'b0;
    n_cmp++; if (cyc !== 38) begin n_bad++; $display("FAIL dz_neg_latency got %0d want 38", cyc); end
    n_cmp++; if (bus.quot_out !== 32'h8000_0000) begin n_bad++; $display("FAIL dz_neg_quot got %h want 80000000", bus.quot_out); end
    n_cmp++; if (bus.err_out !== 1'b1) begin n_bad++; $display("FAIL dz_neg_err got %b want 1", bus.err_out); end
    step();
    bus.num_in[0 +: 32] = 32'd5;
    bus.req_in[0] = 1'b1;
    wait_ack(0, 100, cyc);
    bus.req_in[0] = 1'b0;
    n_cmp++; if (cyc !== 38) begin n_bad++; $display("FAIL dz_pos_latency got %0d want 38", cyc); end
    n_cmp++; if (bus.quot_out !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL dz_pos_quot got %h want 7fffffff", bus.quot_out); end
    n_cmp++; if (bus.err_out !== 1'b1) begin n_bad++; $display("FAIL dz_pos_err got %b want 1", bus.err_out); end
    step();
  endtask

  task automatic test_not_ready();
    int cyc;
    bus.div_rfd_in = 1'b0;
    bus.num_in[64 +: 32] = 32'd90;
    bus.den_in[32 +: 16] = 16'(-4);
    bus.req_in[2] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (bus.busy_out !== 4'b0000) begin n_bad++; $display("FAIL rfd_busy got %b want 0000", bus.busy_out); end
    n_cmp++; if (bus.div_num_out !== 32'd5) begin n_bad++; $display("FAIL rfd_hold_num got %0d want 5", bus.div_num_out); end
    n_cmp++; if (bus.div_den_out !== 16'd0) begin n_bad++; $display("FAIL rfd_hold_den got %0d want 0", bus.div_den_out); end
    step();
    bus.div_rfd_in = 1'b1;
    wait_ack(2, 100, cyc);
    bus.req_in[2] = 1'b0;
    cyc = cyc + 5;
    n_cmp++; if (cyc !== 43) begin n_bad++; $display("FAIL rfd_latency got %0d want 43", cyc); end
    n_cmp++; if (bus.quot_out !== 32'hFFFF_FFEA) begin n_bad++; $display("FAIL rfd_quot got %h want ffffffea", bus.quot_out); end
    step();
  endtask

  task automatic test_reset_midflight();
    int cyc;
    int acks;
    for (int i = 0; i < 3; i++) begin
      bus.num_in[32*i +: 32] = 32'(30 * (i + 1));
      bus.den_in[16*i +: 16] = 16'd3;
    end
    bus.req_in = 4'b0111;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (bus.busy_out !== 4'b0111) begin n_bad++; $display("FAIL mid_busy got %b want 0111", bus.busy_out); end
    bus.req_in = 4'b0000;
    for (int i = 0; i < 5; i++) step();
    pulse_reset();
    n_cmp++; if (bus.busy_out !== 4'h0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0000", bus.busy_out); end
    n_cmp++; if (bus.quot_out !== 32'h0) begin n_bad++; $display("FAIL mid_rst_quot got %h want 0", bus.quot_out); end
    n_cmp++; if (bus.err_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err got %b want 0", bus.err_out); end
    n_cmp++; if (bus.div_num_out !== 32'h0) begin n_bad++; $display("FAIL mid_rst_num got %h want 0", bus.div_num_out); end
    acks = 0;
    for (int i = 0; i < 45; i++) begin
      if (bus.ack_out !== 4'h0) acks++;
      step();
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL mid_no_ack got %0d want 0", acks); end
    bus.num_in[32 +: 32] = 32'(-77);
    bus.den_in[16 +: 16] = 16'd5;
    bus.req_in[1] = 1'b1;
    wait_ack(1, 100, cyc);
    bus.req_in[1] = 1'b0;
    n_cmp++; if (cyc !== 38) begin n_bad++; $display("FAIL mid_after_latency got %0d want 38", cyc); end
    n_cmp++; if (bus.quot_out !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mid_after_quot got %h want fffffff1", bus.quot_out); end
    step();
  endtask

  task automatic test_fairness();
    int cyc;
    int n_acks;
    int exp_id;
    int last_ack [2];
    logic [1:0] prev_busy;
    logic [31:0] exp_q;
    bus.num_in[0 +: 32]  = 32'd50;
    bus.den_in[0 +: 16]  = 16'd5;
    bus.num_in[32 +: 32] = 32'(-50);
    bus.den_in[16 +: 16] = 16'd5;
    last_ack[0] = -1;
    last_ack[1] = -1;
    prev_busy = 2'b00;
    n_acks = 0;
    cyc = 0;
    bus.req_in = 4'b0011;
    while (n_acks < 20 && cyc < 1000) begin
      step();
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (prev_busy[i] == 1'b0 && bus.busy_out[i] == 1'b1 && last_ack[i] >= 0) begin
          n_cmp++; if (cyc !== last_ack[i] + 2) begin n_bad++; $display("FAIL fair_regrant%0d got %0d want %0d", i, cyc, last_ack[i] + 2); end
        end
      end
      prev_busy = bus.busy_out[1:0];
      if (bus.ack_out !== 4'h0) begin
        exp_id = n_acks % 2;
        exp_q  = (exp_id == 0) ? 32'd10 : 32'hFFFF_FFF6;
        n_cmp++; if (bus.ack_out !== 4'(1 << exp_id)) begin n_bad++; $display("FAIL fair_order%0d got %b want %b", n_acks, bus.ack_out, 4'(1 << exp_id)); end
        n_cmp++; if (bus.quot_out !== exp_q) begin n_bad++; $display("FAIL fair_quot%0d got %h want %h", n_acks, bus.quot_out, exp_q); end
        last_ack[exp_id] = cyc;
        n_acks++;
        if (n_acks == 20) bus.req_in = 4'b0000;
      end
    end
    n_cmp++; if (n_acks !== 20) begin n_bad++; $display("FAIL fair_count got %0d want 20", n_acks); end
    bus.req_in = 4'b0000;
    for (int i = 0; i < 45; i++) step();
  endtask

  initial begin
    rst_in         = 1'b1;
    bus.req_in     = '0;
    bus.num_in     = '0;
    bus.den_in     = '0;
    bus.div_rfd_in = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_div_zero();
    test_not_ready();
    test_reset_midflight();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
